pwm_gen: RTL and testbench
==========================

PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter and duty width in bits.
REQ-002 The block SHALL have input clk, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have input clk_div, 1 bit: the divided-clock level from the upstream clock divider, synchronous to clk.
REQ-005 The block SHALL have input duty, WIDTH bits: the requested duty value.
REQ-006 The block SHALL have input duty_valid, 1 bit: duty is presented this cycle.
REQ-007 The block SHALL have output duty_ready, 1 bit: the block can accept duty this cycle.
REQ-008 The block SHALL have output pwm_out, 1 bit: the PWM waveform.
REQ-009 The block SHALL have output period_start, 1 bit: a one-clk pulse at the start of each PWM period.

Function
REQ-010 The block SHALL register clk_div into clk_div_q every clk and form tick = clk_div AND NOT clk_div_q, one clk wide per clk_div rising edge.
REQ-011 The block SHALL hold a WIDTH-bit counter cnt that increments by 1 on each tick and holds otherwise.
REQ-012 On a tick with cnt = 2^WIDTH-1, cnt SHALL wrap to 0 (wrap tick).
REQ-013 The block SHALL register pwm_out every clk as (cnt < duty_active), giving 1 clk latency from cnt or duty_active to pwm_out.
REQ-014 duty = 0 SHALL give pwm_out permanently low; duty = 2^WIDTH-1 SHALL give pwm_out high for 2^WIDTH-1 of 2^WIDTH ticks (100% is not reachable).
REQ-015 The block SHALL use a one-entry pending buffer; duty_ready SHALL equal NOT pending_full, combinationally.
REQ-016 When duty_valid AND duty_ready, the block SHALL capture duty into pending and set pending_full on the same edge.
REQ-017 While duty_ready is low, duty_valid SHALL be ignored, and the pending value SHALL NOT be overwritten.
REQ-018 On a wrap tick with pending_full set, the block SHALL load duty_active from pending and clear pending_full on the same edge; duty_active SHALL never change at any other time.
REQ-019 Simultaneous accept and wrap tick (pending empty) SHALL capture the value into pending; that value SHALL apply at the following wrap tick.
REQ-020 period_start SHALL be registered and pulse high for exactly 1 clk, on the clk after each wrap tick.
REQ-021 A clk_div held high or held low SHALL generate no ticks, and the counter SHALL freeze.

Reset
REQ-022 While rst is high, the block SHALL clear cnt, duty_active, pending and pending_full to 0.
REQ-023 While rst is high, the block SHALL clear clk_div_q and period_start to 0, and duty_ready SHALL be 1.
REQ-024 While rst is high, pwm_out SHALL be at its inactive level: 0, or 1 when PWM_INVERT_EN is defined.
REQ-025 An rst asserted mid-period SHALL discard any pending duty; the first tick after release SHALL advance cnt from 0 to 1.

Configuration
REQ-026 When macro PWM_INVERT_EN is defined, pwm_out SHALL be the logical inverse of the REQ-013 value, including at reset, for active-low LED drivers.
REQ-027 When PWM_INVERT_EN is undefined, pwm_out SHALL be active-high as in REQ-013; no other behaviour SHALL differ between the two builds.

Verification (WIDTH = 8; clk_div rising edge every 8 clk)
REQ-028 Reset release, no duty written -> pwm_out = 0 for 2 full periods; period_start pulses every 2048 clk; duty_ready = 1.
REQ-029 Write duty = 64 -> from the next wrap tick onward, pwm_out high for 512 clk then low for 1536 clk per period.
REQ-030 Write 64, then write 200 before the wrap tick -> the second write stalls (duty_ready = 0); 64 applies at the first wrap, 200 is accepted after it and applies at the second wrap.
REQ-031 Duty 0 and duty 255 -> constant 0; 255 high ticks plus 1 low tick per period.
REQ-032 Assert rst in the middle of the period at cnt = 100, with pending_full = 1 -> all outputs match REQ-022..024 immediately; after release, the pending value is never applied.
REQ-033 PWM_INVERT_EN build with duty = 64 -> pwm_out is the exact complement of REQ-029 and equals 1 during reset.

Source files
------------

// File: rtl/pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_gen
//  Description : Counter-compare PWM generator with a one-entry duty buffer.
//                Duty updates only at period wrap. Build macro PWM_INVERT_EN
//                selects an active-low pwm_out for LED drivers.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div,
    input  logic [WIDTH-1:0] duty,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_start
);

`ifdef PWM_INVERT_EN
    localparam logic c_PWM_IDLE = 1'b1;
`else
    localparam logic c_PWM_IDLE = 1'b0;
`endif

    logic             clk_div_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_active_q, duty_active_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             pending_full_q, pending_full_d;
    logic             pwm_q, pwm_d;
    logic             period_start_q, period_start_d;

    logic             w_tick;
    logic             w_wrap;
    logic             w_accept;

    assign w_tick     = clk_div & ~clk_div_q;
    assign w_wrap     = w_tick && (cnt_q == {WIDTH{1'b1}});
    assign duty_ready = ~pending_full_q;
    assign w_accept   = duty_valid & duty_ready;

    always_comb begin
        cnt_d          = cnt_q;
        duty_active_d  = duty_active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        period_start_d = w_wrap;

        if (w_tick) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Accept and load are exclusive: accept needs an empty buffer, load a full one.
        if (w_accept) begin
            pending_d      = duty;
            pending_full_d = 1'b1;
        end else if (w_wrap && pending_full_q) begin
            duty_active_d  = pending_q;
            pending_full_d = 1'b0;
        end

        pwm_d = (cnt_q < duty_active_q) ^ c_PWM_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_div_q      <= 1'b0;
            cnt_q          <= '0;
            duty_active_q  <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            pwm_q          <= c_PWM_IDLE;
            period_start_q <= 1'b0;
        end else begin
            clk_div_q      <= clk_div;
            cnt_q          <= cnt_d;
            duty_active_q  <= duty_active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_gen
//  Description : Directed self-checking bench for pwm_gen (WIDTH = 8,
//                clk_div rising every 8 clk, so one period is 2048 clk).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_gen;
    localparam int WIDTH = 8;
`ifdef PWM_INVERT_EN
    localparam logic c_INV = 1'b1;
`else
    localparam logic c_INV = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_div;
    logic [WIDTH-1:0] duty;
    logic             duty_valid;
    logic             duty_ready;
    logic             pwm_out;
    logic             period_start;

    int checks = 0;
    int errors = 0;
    int divcnt = 0;
    int act;
    int len;

    always #5 clk = ~clk;

    pwm_gen #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_div      (clk_div),
        .duty         (duty),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clk step; drops duty_valid once the handshake completes and
    // advances the divided clock (rising edge every 8 clk).
    task automatic clk1();
        logic rdy;
        rdy = duty_ready;
        @(posedge clk);
        #1;
        if (duty_valid && rdy) duty_valid = 1'b0;
        if (!rst) begin
            divcnt++;
            clk_div = divcnt[2];
        end
    endtask

    // Runs up to and including the next period_start sample; counts active pwm samples.
    task automatic measure(output int n_act, output int n_len);
        n_act = 0;
        n_len = 0;
        for (int i = 0; i < 4200; i++) begin
            clk1();
            n_len++;
            if (pwm_out !== c_INV) n_act++;
            if (period_start === 1'b1) break;
        end
    endtask

    initial begin
        rst        = 1'b1;
        clk_div    = 1'b0;
        duty       = '0;
        duty_valid = 1'b0;
        repeat (3) clk1();
        check("rst_pwm", pwm_out, c_INV);
        check("rst_period_start", period_start, 0);
        check("rst_ready", duty_ready, 1);

        // First tick lands 5 clk after release, wrap is the 256th tick.
        rst    = 1'b0;
        divcnt = 0;
        measure(act, len);
        check("first_period_len", len, 2045);
        check("first_period_act", act, 0);
        measure(act, len);
        check("idle_len_1", len, 2048);
        check("idle_act_1", act, 0);
        measure(act, len);
        check("idle_len_2", len, 2048);
        check("idle_act_2", act, 0);
        check("idle_ready", duty_ready, 1);

        duty = 8'd64; duty_valid = 1'b1;
        measure(act, len);
        check("d64_pre_act", act, 0);
        check("d64_ready_after_wrap", duty_ready, 1);
        measure(act, len);
        check("d64_len", len, 2048);
        check("d64_act", act, 512);

        // Second write stalls behind a full buffer until the wrap frees it.
        duty = 8'd128; duty_valid = 1'b1;
        clk1();
        check("pend_full_ready", duty_ready, 0);
        duty = 8'd200; duty_valid = 1'b1;
        clk1();
        check("stall_ready", duty_ready, 0);
        measure(act, len);
        check("stall_len", len, 2046);
        check("stall_act", act, 510);
        check("stall_ready_after_wrap", duty_ready, 1);
        measure(act, len);
        check("d128_act", act, 1024);
        measure(act, len);
        check("d200_act", act, 1600);

        duty = 8'd255; duty_valid = 1'b1;
        measure(act, len);
        check("d255_pre_act", act, 1600);
        measure(act, len);
        check("d255_act", act, 2040);
        check("d255_len", len, 2048);

        duty = 8'd0; duty_valid = 1'b1;
        measure(act, len);
        check("d0_pre_act", act, 2040);
        measure(act, len);
        check("d0_act", act, 0);

        // Accept on the exact wrap edge: value waits one more period.
        repeat (2047) clk1();
        duty = 8'd32; duty_valid = 1'b1;
        clk1();
        check("sim_wrap_ps", period_start, 1);
        check("sim_wrap_ready", duty_ready, 0);
        measure(act, len);
        check("sim_wrap_old_act", act, 0);
        check("sim_wrap_len", len, 2048);
        measure(act, len);
        check("sim_wrap_new_act", act, 256);

        // Reset at cnt = 100 with a pending value that must be dropped.
        duty = 8'd16; duty_valid = 1'b1;
        repeat (801) clk1();
        check("mid_pending_ready", duty_ready, 0);
        rst     = 1'b1;
        clk_div = 1'b0;
        divcnt  = 0;
        #1;
        check("mid_rst_pwm", pwm_out, c_INV);
        check("mid_rst_ps", period_start, 0);
        check("mid_rst_ready", duty_ready, 1);
        repeat (2) clk1();
        check("mid_rst_pwm_held", pwm_out, c_INV);
        rst = 1'b0;
        measure(act, len);
        check("post_rst_len", len, 2045);
        check("post_rst_act", act, 0);
        measure(act, len);
        check("post_rst_act_2", act, 0);
        check("post_rst_len_2", len, 2048);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
